keyword_nest_checker: RTL and testbench
=======================================

# keyword_nest_checker

- Streaming checker that consumes one ASCII character per valid cycle.
- Tracks nesting of the keyword pair `begin`/`end` across whitespace-delimited words.
- Reports whether the stream seen so far is balanced, plus current depth, peak depth and sticky error flags.
- Parametrised successor of the single-counter block checker: configurable depth width, case-sensitivity mode, input qualifier, multiple delimiter characters, saturating overflow detection and a synchronous clear. Sits after the character source in the text-processing datapath.

## Interface

- `DEPTH_W`, 8: width of the depth and peak counters.
- `MAX_DEPTH`, 2**DEPTH_W-1: highest legal nesting depth. Must be ≤ 2**DEPTH_W-1.
- `CASE_SENS`, 0: 0 means keywords match in any letter case; 1 means lowercase only.
- `clk`, in, 1: clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `clr`, in, 1: synchronous clear. Same effect as reset; has priority over `in_valid`.
- `in_valid`, in, 1: qualifies `in`. When low, all state holds.
- `in`, in, 8: ASCII character.
- `result`, out, 1: combinational. 1 when the stream so far, taken as ending now, is balanced and error-free.
- `depth`, out, DEPTH_W: committed nesting depth (registered).
- `peak`, out, DEPTH_W: maximum committed depth since reset or clear.
- `err_underflow`, out, 1: sticky. Set when an `end` is committed at depth 0.
- `err_overflow`, out, 1: sticky. Set when a `begin` is committed at depth `MAX_DEPTH`.

## Operation

- **Delimiters:** 0x20 (space), 0x09 (tab), 0x0A (LF), 0x0D (CR). Any other byte is a word character.
- **Letter matching:** with `CASE_SENS`=0, `B`/`b`, `E`/`e`, etc. are equivalent.
- **FSM states:** DELIM (reset state), OTHER, B, BE, BEG, BEGI, BEGIN, E, EN, END.
- **Transitions on a valid cycle:**
  - From DELIM: `b` → B, `e` → E, delimiter → DELIM, any other character → OTHER.
  - Keyword prefix states: the next expected letter advances along `b-e-g-i-n` or `e-n-d`. A delimiter → DELIM. Anything else → OTHER.
  - OTHER: delimiter → DELIM, otherwise stay in OTHER.
  - BEGIN or END followed by a delimiter → DELIM and commits the keyword.
  - BEGIN or END followed by a word character → OTHER, with no commit (`beginx`, `ends` are plain words).
- **Committing `begin`:**
  - If `depth` < `MAX_DEPTH`: `depth` increments, and `peak` ← max(`peak`, `depth`+1).
  - Otherwise: `depth` holds and `err_overflow` ← 1.
- **Committing `end`:**
  - If `depth` > 0: `depth` decrements.
  - Otherwise: `depth` stays 0 and `err_underflow` ← 1.
- **Pending keyword:** a word that is still open (state BEGIN or END) is reflected in `result` only, never in `depth`.
- **`result` equation:** `result` = !`err_underflow` & !`err_overflow` & term, where term is:
  - state END: (`depth`==1)
  - state BEGIN: 0
  - any other state: (`depth`==0)
- **Errors:** stay set until reset or `clr`. Further commits still update `depth` per the rules above, but `result` remains 0.

## Timing

- **Reset or clear:** state DELIM, `depth`=0, `peak`=0, both error flags 0, so `result`=1.
- **Async reset:** takes effect immediately, including mid-word. A partial keyword is discarded.
- **`depth`, `peak`, error flags:** change on the edge that samples the committing delimiter. Latency is 1 cycle after the delimiter is presented.
- **`result` on a keyword's last letter:** reflects the pending keyword in the same cycle that the letter's edge updates the state (e.g. `result` rises right after the `d` of a closing `end`).
- **`in_valid`=0 cycles:** insert no character. A word may be split across idle cycles.
- **`clr` together with `in_valid`=1:** `clr` wins and the character is dropped.
- **Multiple delimiters:** consecutive delimiters are equivalent to one.
- **Start of stream:** a leading delimiter is not required; reset state is DELIM.

## Test plan

1. `begin end` with no trailing space:
   - `result`=0 after `begin `, with `depth`=1 and `peak`=1.
   - `result`=1 right after `d`, with `depth` still 1.
   - Then send a space: `depth`=0, `result`=1.
2. `end begin end`:
   - Committing the first `end` sets `err_underflow`=1.
   - `result` stays 0 for the rest of the stream even though the final `depth`=0.
   - `clr` returns `result`=1.
3. `BeGiN\tbegins\nEND\r`, with `CASE_SENS`=0:
   - `depth` goes 1, then 1 (`begins` is not a keyword), then 0; `result`=1.
   - Same stream with `CASE_SENS`=1: `depth` stays 0, `result`=1.
4. `DEPTH_W`=2, `MAX_DEPTH`=3, stream of four `begin ` words:
   - `depth` saturates at 3, `peak`=3, `err_overflow`=1, `result`=0.
5. `beg` + idle cycles with `in_valid`=0 + `in` + ` end `:
   - `depth` goes 1 then 0; `result`=1.
   - Bytes presented while `in_valid`=0 are ignored.
6. Async reset pulse:
   - Applied between `en` and `d` with `depth`=2: all outputs return to reset values immediately.
   - Then `d ` leaves `depth`=0 (the word becomes OTHER) and `result`=1.

Source files
------------

// File: rtl/keyword_nest_checker.sv
// keyword_nest_checker: tracks begin/end nesting over a delimited ASCII stream.
// It reports the balance state, the current and peak depth, and sticky error flags.
module keyword_nest_checker #(
  parameter int DEPTH_W   = 8,
  parameter int MAX_DEPTH = 2**DEPTH_W-1,
  parameter bit CASE_SENS = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic [DEPTH_W-1:0] peak,
  output logic               err_underflow,
  output logic               err_overflow
);
  typedef enum logic [3:0] {
    S_DELIM, S_OTHER, S_B, S_BE, S_BEG, S_BEGI, S_BEGIN, S_E, S_EN, S_END
  } state_t;
  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);
  state_t state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d, peak_q, peak_d, inc;
  logic eu_q, eu_d, eo_q, eo_d;
  logic [7:0] ch;
  logic is_delim;
  always_comb begin
    ch = (!CASE_SENS && in >= 8'h41 && in <= 8'h5A) ? (in | 8'h20) : in;
    is_delim = in == 8'h20 || in == 8'h09 || in == 8'h0A || in == 8'h0D;
    state_d = is_delim ? S_DELIM : S_OTHER;
    if (!is_delim)
      case (state_q)
        S_DELIM: state_d = ch == "b" ? S_B : ch == "e" ? S_E : S_OTHER;
        S_B:     state_d = ch == "e" ? S_BE    : S_OTHER;
        S_BE:    state_d = ch == "g" ? S_BEG   : S_OTHER;
        S_BEG:   state_d = ch == "i" ? S_BEGI  : S_OTHER;
        S_BEGI:  state_d = ch == "n" ? S_BEGIN : S_OTHER;
        S_E:     state_d = ch == "n" ? S_EN    : S_OTHER;
        S_EN:    state_d = ch == "d" ? S_END   : S_OTHER;
        default: state_d = S_OTHER;
      endcase
  end
  // A keyword only takes effect when the delimiter that closes its word is sampled.
  always_comb begin
    depth_d = depth_q;
    peak_d  = peak_q;
    eu_d    = eu_q;
    eo_d    = eo_q;
    inc     = depth_q + DEPTH_W'(1);
    if (is_delim && state_q == S_BEGIN) begin
      if (depth_q < MAX_D) begin
        depth_d = inc;
        peak_d  = inc > peak_q ? inc : peak_q;
      end else
        eo_d = 1'b1;
    end
    if (is_delim && state_q == S_END) begin
      if (depth_q != '0)
        depth_d = depth_q - DEPTH_W'(1);
      else
        eu_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_DELIM;
      depth_q <= '0;
      peak_q  <= '0;
      eu_q    <= 1'b0;
      eo_q    <= 1'b0;
    end else if (clr) begin
      state_q <= S_DELIM;
      depth_q <= '0;
      peak_q  <= '0;
      eu_q    <= 1'b0;
      eo_q    <= 1'b0;
    end else if (in_valid) begin
      state_q <= state_d;
      depth_q <= depth_d;
      peak_q  <= peak_d;
      eu_q    <= eu_d;
      eo_q    <= eo_d;
    end
  end
  assign result = !eu_q && !eo_q &&
                  (state_q == S_END   ? depth_q == DEPTH_W'(1) :
                   state_q == S_BEGIN ? 1'b0 : depth_q == '0);
  assign depth         = depth_q;
  assign peak          = peak_q;
  assign err_underflow = eu_q;
  assign err_overflow  = eo_q;
endmodule

// File: tb/tb_keyword_nest_checker.sv
// tb_keyword_nest_checker: drives three parameterisations of the checker in parallel.
// A word-level string model predicts the outputs of each instance.
module tb_keyword_nest_checker;
  logic clk = 0, reset = 1, clr = 0, in_valid = 0;
  logic [7:0] in_c = 0;
  always #5 clk = ~clk;
  logic       res0, res1, res2, eu0, eu1, eu2, eo0, eo1, eo2;
  logic [7:0] dep0, dep1, pk0, pk1;
  logic [1:0] dep2, pk2;
  keyword_nest_checker d0 (.clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in(in_c),
    .result(res0), .depth(dep0), .peak(pk0), .err_underflow(eu0), .err_overflow(eo0));
  keyword_nest_checker #(.CASE_SENS(1)) d1 (.clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in(in_c),
    .result(res1), .depth(dep1), .peak(pk1), .err_underflow(eu1), .err_overflow(eo1));
  keyword_nest_checker #(.DEPTH_W(2), .MAX_DEPTH(3)) d2 (.clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in(in_c),
    .result(res2), .depth(dep2), .peak(pk2), .err_underflow(eu2), .err_overflow(eo2));
  logic [7:0] o_dep[3], o_pk[3];
  logic       o_res[3], o_eu[3], o_eo[3];
  assign o_dep[0] = dep0;
  assign o_dep[1] = dep1;
  assign o_dep[2] = {6'b0, dep2};
  assign o_pk[0]  = pk0;
  assign o_pk[1]  = pk1;
  assign o_pk[2]  = {6'b0, pk2};
  assign o_res[0] = res0;
  assign o_res[1] = res1;
  assign o_res[2] = res2;
  assign o_eu[0]  = eu0;
  assign o_eu[1]  = eu1;
  assign o_eu[2]  = eu2;
  assign o_eo[0]  = eo0;
  assign o_eo[1]  = eo1;
  assign o_eo[2]  = eo2;
  int total = 0, bad = 0;
  int    maxd[3] = '{255, 255, 3};
  bit    cs[3]   = '{0, 1, 0};
  int    m_depth[3], m_peak[3];
  bit    m_eu[3], m_eo[3];
  string m_word[3];
  function automatic bit is_dl(logic [7:0] c);
    return c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D;
  endfunction
  task automatic m_apply(bit v, bit c, logic [7:0] ch);
    for (int k = 0; k < 3; k++) begin
      if (c) begin
        m_depth[k] = 0; m_peak[k] = 0; m_eu[k] = 0; m_eo[k] = 0; m_word[k] = "";
      end else if (v) begin
        if (is_dl(ch)) begin
          if (m_word[k] == "begin") begin
            if (m_depth[k] < maxd[k]) begin
              m_depth[k]++;
              if (m_depth[k] > m_peak[k]) m_peak[k] = m_depth[k];
            end else m_eo[k] = 1;
          end else if (m_word[k] == "end") begin
            if (m_depth[k] > 0) m_depth[k]--; else m_eu[k] = 1;
          end
          m_word[k] = "";
        end else begin
          logic [7:0] lc;
          lc = (!cs[k] && ch >= 8'h41 && ch <= 8'h5A) ? ch + 8'd32 : ch;
          m_word[k] = $sformatf("%s%c", m_word[k], lc);
        end
      end
    end
  endtask
  function automatic bit m_res(int k);
    if (m_eu[k] || m_eo[k]) return 0;
    if (m_word[k] == "end") return m_depth[k] == 1;
    if (m_word[k] == "begin") return 0;
    return m_depth[k] == 0;
  endfunction
  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d_result", k), {7'b0, o_res[k]}, {7'b0, m_res(k)});
      chk($sformatf("d%0d_depth", k), o_dep[k], 8'(m_depth[k]));
      chk($sformatf("d%0d_peak", k), o_pk[k], 8'(m_peak[k]));
      chk($sformatf("d%0d_err_underflow", k), {7'b0, o_eu[k]}, {7'b0, m_eu[k]});
      chk($sformatf("d%0d_err_overflow", k), {7'b0, o_eo[k]}, {7'b0, m_eo[k]});
    end
  endtask
  task automatic step(bit v, logic [7:0] ch, bit c);
    @(negedge clk);
    in_valid = v; in_c = ch; clr = c;
    @(posedge clk);
    m_apply(v, c, ch);
    #1;
    check_all();
  endtask
  task automatic send(string s);
    for (int i = 0; i < s.len(); i++) step(1, s[i], 0);
  endtask
  typedef struct {
    string           txt;
    logic [2:0][7:0] dep;
    logic [2:0]      res;
    logic [2:0][7:0] pk;
  } vec_t;
  vec_t  vecs[5];
  string words[10] = '{"begin", "end", "BEGIN", "End", "beginx", "ends", "x", "be", "en", "eNd"};
  logic [7:0] dls[4] = '{8'h20, 8'h09, 8'h0A, 8'h0D};
  initial begin
    // fields packed as {d2, d1, d0}
    vecs[0] = '{"begin end",                 {8'd1, 8'd1, 8'd1}, 3'b111, {8'd1, 8'd1, 8'd1}};
    vecs[1] = '{"end begin end ",            {8'd0, 8'd0, 8'd0}, 3'b000, {8'd1, 8'd1, 8'd1}};
    vecs[2] = '{"BeGiN\tbegins\nEND\r",      {8'd0, 8'd0, 8'd0}, 3'b111, {8'd1, 8'd0, 8'd1}};
    vecs[3] = '{"begin begin begin begin ",  {8'd3, 8'd4, 8'd4}, 3'b000, {8'd3, 8'd4, 8'd4}};
    vecs[4] = '{"begin begin end",           {8'd2, 8'd2, 8'd2}, 3'b000, {8'd2, 8'd2, 8'd2}};
    m_apply(0, 1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    check_all();
    chk("reset_result", {7'b0, res0}, 8'd1);
    foreach (vecs[i]) begin
      step(0, 0, 1);
      send(vecs[i].txt);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("vec%0d_d%0d_depth", i, k), o_dep[k], vecs[i].dep[k]);
        chk($sformatf("vec%0d_d%0d_result", i, k), {7'b0, o_res[k]}, {7'b0, vecs[i].res[k]});
        chk($sformatf("vec%0d_d%0d_peak", i, k), o_pk[k], vecs[i].pk[k]);
      end
    end
    step(0, 0, 1);
    send("begin ");
    chk("t1_open_result", {7'b0, res0}, 8'd0);
    chk("t1_open_depth", dep0, 8'd1);
    send("end");
    chk("t1_pending_result", {7'b0, res0}, 8'd1);
    chk("t1_pending_depth", dep0, 8'd1);
    send(" ");
    chk("t1_closed_depth", dep0, 8'd0);
    send("end begin end ");
    chk("t2_underflow", {7'b0, eu0}, 8'd1);
    chk("t2_result", {7'b0, res0}, 8'd0);
    step(0, 0, 1);
    chk("t2_clr_result", {7'b0, res0}, 8'd1);
    step(0, 0, 1);
    send("beg");
    step(0, "x", 0);
    step(0, " ", 0);
    step(0, "q", 0);
    send("in");
    chk("t5_pending_depth", dep0, 8'd0);
    send(" ");
    chk("t5_depth1", dep0, 8'd1);
    send("end ");
    chk("t5_depth0", dep0, 8'd0);
    chk("t5_result", {7'b0, res0}, 8'd1);
    send("begin");
    step(1, " ", 1);
    chk("clr_drops_char", dep0, 8'd0);
    send("begin begin en");
    chk("t6_depth2", dep0, 8'd2);
    @(negedge clk);
    #2 reset = 1;
    m_apply(0, 1, 0);
    #1;
    check_all();
    chk("t6_async_depth", dep0, 8'd0);
    chk("t6_async_result", {7'b0, res0}, 8'd1);
    reset = 0;
    send("d ");
    chk("t6_after_depth", dep0, 8'd0);
    chk("t6_after_result", {7'b0, res0}, 8'd1);
    for (int n = 0; n < 300; n++) begin
      string w;
      w = words[$urandom_range(0, 9)];
      if ($urandom_range(0, 49) == 0) step(1, "b", 1);
      for (int i = 0; i < w.len(); i++) begin
        if ($urandom_range(0, 3) == 0) step(0, 8'($urandom), 0);
        step(1, w[i], 0);
      end
      repeat ($urandom_range(1, 2)) step(1, dls[$urandom_range(0, 3)], 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
